// File: rtl/screen_mem_arbiter.sv
// Screen RAM arbiter: VGA fetch has strict priority with fixed latency,
// CPU writes are posted through a 1-entry buffer, CPU reads wait for it.
module screen_mem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU
    } tag_t;

    state_t state;
    state_t state_nx;
    tag_t   tag0;
    tag_t   tag1;

    logic              wbuf_full;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;

    logic             in_idle;
    logic             rd_done;
    logic             grant_vid;
    logic             grant_drain;
    logic             grant_rd;
    logic             wr_accept;
    logic             cpu_pending;
    logic             cpu_win;
    logic [CNT_W-1:0] starve_cnt;

    // Slot arbitration: video, then buffer drain, then CPU read issue
    always_comb begin
        grant_vid   = vid_req;
        grant_drain = !vid_req && wbuf_full;
        grant_rd    = !vid_req && !wbuf_full && in_idle
                      && cpu_req && !cpu_we;
        // cpu_ack high means the requester has not yet seen its last ack
        wr_accept   = in_idle && cpu_req && cpu_we && !cpu_ack
                      && (!wbuf_full || grant_drain);
        cpu_pending = wbuf_full
                      || (in_idle && cpu_req && !cpu_we && !cpu_ack);
        cpu_win     = grant_drain || grant_rd;
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Read FSM next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (grant_rd) state_nx = S_RD_WAIT;
            S_RD_WAIT: if (rd_done)  state_nx = S_ACK;
            S_ACK:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Read FSM decoded outputs
    always_comb begin
        in_idle = (state == S_IDLE);
        rd_done = (state == S_RD_WAIT) && (tag1 == TAG_CPU);
    end

    // Register the winning request onto the RAM port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (grant_vid) begin
            mem_addr  <= vid_addr;
            mem_we    <= 1'b0;
        end else if (grant_drain) begin
            mem_addr  <= wbuf_addr;
            mem_we    <= 1'b1;
            mem_wdata <= wbuf_data;
        end else if (grant_rd) begin
            mem_addr  <= cpu_addr;
            mem_we    <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Tag pipe follows each slot to the cycle its read data returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag0 <= TAG_NONE;
            tag1 <= TAG_NONE;
        end else begin
            if (grant_vid)     tag0 <= TAG_VID;
            else if (grant_rd) tag0 <= TAG_CPU;
            else               tag0 <= TAG_NONE;
            tag1 <= tag0;
        end
    end

    // Steer returning RAM data to the video or CPU side
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            vid_valid <= (tag1 == TAG_VID);
            if (tag1 == TAG_VID) vid_data <= mem_rdata;
            cpu_ack <= wr_accept || rd_done;
            if (rd_done) cpu_rdata <= mem_rdata;
        end
    end

    // Posted write buffer; a reload wins over the drain that empties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbuf_full <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
        end else if (wr_accept) begin
            wbuf_full <= 1'b1;
            wbuf_addr <= cpu_addr;
            wbuf_data <= cpu_wdata;
        end else if (grant_drain) begin
            wbuf_full <= 1'b0;
        end
    end

    // Starvation counter saturates at the limit; flag is sticky
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt  <= '0;
            cpu_starved <= 1'b0;
        end else if (cpu_win) begin
            starve_cnt <= '0;
        end else if (cpu_pending && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == CNT_MAX - 1'b1) cpu_starved <= 1'b1;
        end
    end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Bench for screen_mem_arbiter: RAM model, scoreboard queues,
// directed timing cases and randomized mixed traffic.
module tb_screen_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_starved;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    screen_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(64)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_starved(cpu_starved),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
        if (a == 13'h0010) return 16'hBEEF;
        return {a[3:0], a[12:1]} ^ 16'h5A3C;
    endfunction

    // Synchronous single-port RAM, one cycle read latency
    logic [DW-1:0] ram_w [8192];
    bit            ram_v [8192];
    always @(posedge clk) begin
        if (mem_we) begin
            ram_w[mem_addr] <= mem_wdata;
            ram_v[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_v[mem_addr] ? ram_w[mem_addr] : init_word(mem_addr);
    end

    // Reference: CPU-visible memory contents in program order
    logic [DW-1:0] ref_mem [int];
    function automatic logic [DW-1:0] exp_read(logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    typedef struct { int cyc; logic [DW-1:0] data; } vexp_t;
    typedef struct { logic we; logic [DW-1:0] data; } cexp_t;
    vexp_t vq[$];
    cexp_t cq[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vid_issue(logic [AW-1:0] a);
        vexp_t e;
        vid_req = 1'b1;
        vid_addr = a;
        e.cyc = cyc + 3;
        e.data = init_word(a);
        vq.push_back(e);
    endtask

    task automatic cpu_start(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        cexp_t e;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_req = 1'b1;
        e.we = we;
        e.data = we ? d : exp_read(a);
        cq.push_back(e);
        if (we) ref_mem[int'(a)] = d;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int ack_cyc);
        int n;
        n = 0;
        cpu_start(we, a, d);
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 300);
        ack_cyc = cyc;
        if (!cpu_ack) check("cpu_ack_timeout", cpu_ack, 1);
        cpu_req = 1'b0;
    endtask

    // Monitor: pop expectations whenever the DUT presents a result
    always @(negedge clk) begin
        vexp_t ve;
        cexp_t ce;
        if (vq.size() > 0 && vq[0].cyc < cyc) begin
            ve = vq.pop_front();
            check("vid_valid_missing_cycle", cyc, ve.cyc);
        end
        if (vid_valid) begin
            if (vq.size() == 0) begin
                check("vid_spurious_valid", vid_valid, 0);
            end else begin
                ve = vq.pop_front();
                check("vid_latency", cyc, ve.cyc);
                check("vid_data", vid_data, ve.data);
            end
        end
        if (cpu_ack) begin
            if (cq.size() == 0) begin
                check("cpu_spurious_ack", cpu_ack, 0);
            end else begin
                ce = cq.pop_front();
                if (!ce.we) check("cpu_rdata", cpu_rdata, ce.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, wack, rack, bad;
        // Reset state
        #1 reset = 1'b0;
        #1;
        check("rst_vid_valid", vid_valid, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_starved", cpu_starved, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();

        // Video fetch latency and slot
        vid_issue(13'h0010);
        tick();
        vid_req = 1'b0;
        check("t1_mem_addr", mem_addr, 13'h0010);
        check("t1_mem_we", mem_we, 0);
        repeat (4) tick();

        // Posted write then read-after-write
        s = cyc;
        cpu_op(1'b1, 13'h0020, 16'h1234, wack);
        check("t2_wr_ack_lat", wack - s, 1);
        tick();
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_addr", mem_addr, 13'h0020);
        check("t2_mem_wdata", mem_wdata, 16'h1234);
        cpu_op(1'b0, 13'h0020, 16'h0, rack);
        check("t3_rd_after_wr_ack", rack - wack, 4);
        repeat (3) tick();

        // Video collides with a ready drain
        cpu_start(1'b1, 13'h0040, 16'hA5A5);
        tick();
        check("t5_wr_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        vid_issue(13'h1ABC);
        tick();
        vid_req = 1'b0;
        check("t5_vid_slot_we", mem_we, 0);
        check("t5_vid_slot_addr", mem_addr, 13'h1ABC);
        tick();
        check("t5_drain_we", mem_we, 1);
        check("t5_drain_addr", mem_addr, 13'h0040);
        repeat (4) tick();

        // Randomized mixed traffic
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    if ($urandom_range(0, 9) < 4)
                        vid_issue(13'h1000 | 13'($urandom_range(0, 4095)));
                    else
                        vid_req = 1'b0;
                    tick();
                end
                vid_req = 1'b0;
            end
            begin
                int ac;
                for (int i = 0; i < 40; i++) begin
                    cpu_op(1'($urandom_range(0, 1)),
                           13'(13'h0100 + $urandom_range(0, 15)),
                           16'($urandom), ac);
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
        join
        repeat (6) tick();
        check("rand_vid_queue_empty", vq.size(), 0);
        check("rand_cpu_queue_empty", cq.size(), 0);
        check("rand_not_starved", cpu_starved, 0);

        // Continuous video with a full buffer starves the CPU
        cpu_start(1'b1, 13'h0030, 16'h5555);
        tick();
        check("t4_wr_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            vid_issue(13'(13'h1800 + i));
            if (i == 63) check("t4_starved_before", cpu_starved, 0);
            if (i == 64) check("t4_starved_at_limit", cpu_starved, 1);
            if (i >= 1 && mem_we) bad++;
            tick();
        end
        vid_req = 1'b0;
        check("t4_no_drain", bad, 0);
        tick();
        check("t4_drain_we", mem_we, 1);
        check("t4_drain_addr", mem_addr, 13'h0030);
        repeat (4) tick();
        check("t4_starved_sticky", cpu_starved, 1);

        // Reset while a CPU read is in flight
        cpu_start(1'b0, 13'h0020, 16'h0);
        tick();
        #2 reset = 1'b0;
        #1;
        check("t6_cpu_ack", cpu_ack, 0);
        check("t6_cpu_rdata", cpu_rdata, 0);
        check("t6_starved", cpu_starved, 0);
        check("t6_vid_data", vid_data, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_wdata", mem_wdata, 0);
        cq.delete();
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (6) tick();
        s = cyc;
        cpu_op(1'b0, 13'h0020, 16'h0, rack);
        check("t6_read_lat", rack - s, 3);
        repeat (4) tick();
        check("end_cpu_queue_empty", cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
